// File: rtl/icache_assoc_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// slave is the cache itself; master is the IF stage plus memory controller around it.
interface icache_assoc_if;
  logic [31:0] pc_from_if;
  logic        inst_enable;
  logic [31:0] inst_to_if;
  logic        addr_enable;
  logic [31:0] addr_to_mem;
  logic        mem_valid;
  logic [31:0] inst_from_mem;
  logic        busy;

  modport slave (
    input  pc_from_if, mem_valid, inst_from_mem,
    output inst_enable, inst_to_if, addr_enable, addr_to_mem, busy
  );

  modport master (
    output pc_from_if, mem_valid, inst_from_mem,
    input  inst_enable, inst_to_if, addr_enable, addr_to_mem, busy
  );
endinterface

// File: rtl/icache_assoc.sv
// Two-way set-associative I-cache, LRU replacement, critical-word-first wrap-around fill with early forward.
// Hit: 0 cycles; fill: LINE_WORDS*(mem latency+1)+1 cycles; rdy low freezes all state and holds outputs.
module icache_assoc #(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64,
  parameter int ADDR_BITS  = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          flush,
  icache_assoc_if.slave bus
);
  localparam int OFF   = $clog2(LINE_WORDS);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = ADDR_BITS - OFF - IDX - 2;

  typedef enum logic [1:0] {IDLE, FILL, GAP, INSTALL} state_t;

  state_t             state, state_nxt;
  logic               valid    [2][SETS];
  logic [TAG_W-1:0]   tag_mem  [2][SETS];
  logic [31:0]        data_mem [2][SETS][LINE_WORDS];
  logic [SETS-1:0]    lru;
  logic [31:0]        line_buf [LINE_WORDS];

  logic [31:OFF+2]    line_q, line_nxt;
  logic [OFF-1:0]     crit, crit_nxt;
  logic [OFF-1:0]     cnt, cnt_nxt;
  logic               aen, aen_nxt;
  logic [31:0]        addr, addr_nxt;
  logic               busy_q, busy_nxt;
  logic               discard, discard_nxt;

  logic               buf_we, install_we, flush_all, lru_touch;

  logic [OFF-1:0]     pc_off;
  logic [IDX-1:0]     pc_idx;
  logic [TAG_W-1:0]   pc_tag;
  logic [1:0]         way_hit;
  logic               hit, fwd;

  logic [OFF-1:0]     fill_off;
  logic [IDX-1:0]     fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               victim;

  assign pc_off   = bus.pc_from_if[OFF+1:2];
  assign pc_idx   = bus.pc_from_if[OFF+IDX+1:OFF+2];
  assign pc_tag   = bus.pc_from_if[ADDR_BITS-1:OFF+IDX+2];

  assign fill_off = crit + cnt;
  assign fill_idx = line_q[OFF+IDX+1:OFF+2];
  assign fill_tag = line_q[ADDR_BITS-1:OFF+IDX+2];
  assign victim   = lru[fill_idx];

  always_comb begin
    way_hit = '0;
    for (int w = 0; w < 2; w++) begin
      way_hit[w] = valid[w][pc_idx] && (tag_mem[w][pc_idx] == pc_tag);
    end
  end

  // INSTALL is writing the arrays this cycle, so lookups are suppressed there.
  assign hit = (|way_hit) && (state != INSTALL);
  assign fwd = bus.mem_valid && (addr == bus.pc_from_if);

  assign bus.inst_enable = fwd || hit;
  assign bus.inst_to_if  = fwd ? bus.inst_from_mem : data_mem[way_hit[1]][pc_idx][pc_off];
  assign bus.addr_enable = aen;
  assign bus.addr_to_mem = addr;
  assign bus.busy        = busy_q;

  always_comb begin
    state_nxt   = state;
    line_nxt    = line_q;
    crit_nxt    = crit;
    cnt_nxt     = cnt;
    aen_nxt     = aen;
    addr_nxt    = addr;
    busy_nxt    = busy_q;
    discard_nxt = discard;
    buf_we      = 1'b0;
    install_we  = 1'b0;
    flush_all   = 1'b0;
    lru_touch   = 1'b0;
    unique case (state)
      IDLE: begin
        lru_touch = hit;
        if (flush) begin
          flush_all = 1'b1;
        end else if (!hit) begin
          line_nxt  = bus.pc_from_if[31:OFF+2];
          crit_nxt  = pc_off;
          cnt_nxt   = '0;
          addr_nxt  = {bus.pc_from_if[31:2], 2'b00};
          aen_nxt   = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        // A flushed fill keeps issuing its requests so memory sees a balanced protocol.
        if (flush) begin
          flush_all   = 1'b1;
          discard_nxt = 1'b1;
        end
        if (bus.mem_valid) begin
          buf_we  = 1'b1;
          aen_nxt = 1'b0;
          if (cnt == OFF'(LINE_WORDS - 1)) begin
            state_nxt = INSTALL;
          end else begin
            cnt_nxt   = cnt + OFF'(1);
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (flush) begin
          flush_all   = 1'b1;
          discard_nxt = 1'b1;
        end
        addr_nxt  = {line_q, fill_off, 2'b00};
        aen_nxt   = 1'b1;
        state_nxt = FILL;
      end
      INSTALL: begin
        if (flush) begin
          flush_all = 1'b1;
        end else begin
          install_we = !discard;
        end
        discard_nxt = 1'b0;
        busy_nxt    = 1'b0;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      line_q  <= '0;
      crit    <= '0;
      cnt     <= '0;
      aen     <= 1'b0;
      addr    <= '0;
      busy_q  <= 1'b0;
      discard <= 1'b0;
    end else if (rdy) begin
      state   <= state_nxt;
      line_q  <= line_nxt;
      crit    <= crit_nxt;
      cnt     <= cnt_nxt;
      aen     <= aen_nxt;
      addr    <= addr_nxt;
      busy_q  <= busy_nxt;
      discard <= discard_nxt;
    end
  end

  // The LRU bit names the victim: a hit points it at the other way, an install flips it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < 2; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid[w][s] <= 1'b0;
        end
      end
      lru <= '0;
    end else if (rdy) begin
      if (flush_all) begin
        for (int w = 0; w < 2; w++) begin
          for (int s = 0; s < SETS; s++) begin
            valid[w][s] <= 1'b0;
          end
        end
      end else if (install_we) begin
        valid[victim][fill_idx] <= 1'b1;
      end
      if (lru_touch) begin
        lru[pc_idx] <= way_hit[0];
      end else if (install_we) begin
        lru[fill_idx] <= ~victim;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && buf_we) begin
      line_buf[fill_off] <= bus.inst_from_mem;
    end
    if (rdy && install_we) begin
      tag_mem[victim][fill_idx] <= fill_tag;
      for (int k = 0; k < LINE_WORDS; k++) begin
        data_mem[victim][fill_idx][k] <= line_buf[k];
      end
    end
  end
endmodule
